// File: rtl/ringbuf_mc.sv
// Multi-channel audio ring buffer: NUM_CH circular sample queues sharing one memory, with a history-offset read tap.
// Define RINGBUF_MC_UNDERRUN_MUTE_EN to return zero data for reads of an empty channel.
module ringbuf_mc #(
  parameter int WIDTH      = 24,
  parameter int DEPTH      = 16,
  parameter int DEPTH_LOG2 = 4,
  parameter int NUM_CH     = 2,
  parameter int CH_LOG2    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  we_i,
  input  logic [CH_LOG2-1:0]    wch_i,
  input  logic                  rd_i,
  input  logic [CH_LOG2-1:0]    rch_i,
  input  logic [DEPTH_LOG2-1:0] offset_i,
  input  logic                  pop_i,
  input  logic                  clr_flags_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  valid_o,
  output logic [CH_LOG2-1:0]    ch_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic [NUM_CH-1:0]     overrun_o,
  output logic [NUM_CH-1:0]     underrun_o
);

  // Memory is sized for every encodable channel so {ch, ptr} never indexes out of range.
  localparam int MEM_WORDS = (1 << CH_LOG2) * DEPTH;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem [MEM_WORDS];

  logic [DEPTH_LOG2-1:0] wptr_q  [NUM_CH];
  logic [DEPTH_LOG2-1:0] wptr_d  [NUM_CH];
  logic [DEPTH_LOG2-1:0] rptr_q  [NUM_CH];
  logic [DEPTH_LOG2-1:0] rptr_d  [NUM_CH];
  logic [DEPTH_LOG2:0]   level_q [NUM_CH];
  logic [DEPTH_LOG2:0]   level_d [NUM_CH];
  logic [NUM_CH-1:0]     overrun_q, overrun_d;
  logic [NUM_CH-1:0]     underrun_q, underrun_d;

  logic [NUM_CH-1:0]     wrSel, popSel, isFull, isEmpty;
  logic [DEPTH_LOG2-1:0] rdPtr, wrPtr;
  logic [DEPTH_LOG2:0]   rdLevel;
  logic [CH_LOG2+DEPTH_LOG2-1:0] raddr, waddr;
  logic                  muteRead;

  logic [WIDTH-1:0]      data_q;
  logic                  valid_q;
  logic [CH_LOG2-1:0]    ch_q;
  logic [DEPTH_LOG2:0]   rdLevel_q;

  always_comb begin
    overrun_d  = clr_flags_i ? '0 : overrun_q;
    underrun_d = clr_flags_i ? '0 : underrun_q;
    wrSel   = '0;
    popSel  = '0;
    isFull  = '0;
    isEmpty = '0;
    rdPtr   = '0;
    rdLevel = '0;
    wrPtr   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wptr_d[c]  = wptr_q[c];
      rptr_d[c]  = rptr_q[c];
      level_d[c] = level_q[c];
      wrSel[c]   = we_i && (wch_i == CH_LOG2'(c));
      popSel[c]  = pop_i && (rch_i == CH_LOG2'(c));
      isFull[c]  = (level_q[c] == LVL_FULL);
      isEmpty[c] = (level_q[c] == '0);

      if (wrSel[c]) begin
        wptr_d[c] = wptr_q[c] + PTR_ONE;
      end
      // Both strobes judge against the pre-cycle level; a pop on a full channel absorbs the drop.
      unique case ({wrSel[c], popSel[c] && !isEmpty[c]})
        2'b11: rptr_d[c] = rptr_q[c] + PTR_ONE;
        2'b10: begin
          if (isFull[c]) begin
            rptr_d[c]    = rptr_q[c] + PTR_ONE;
            overrun_d[c] = 1'b1;
          end else begin
            level_d[c] = level_q[c] + LVL_ONE;
          end
        end
        2'b01: begin
          rptr_d[c]  = rptr_q[c] + PTR_ONE;
          level_d[c] = level_q[c] - LVL_ONE;
        end
        default: ;
      endcase
      if (popSel[c] && isEmpty[c]) begin
        underrun_d[c] = 1'b1;
      end

      if (rch_i == CH_LOG2'(c)) begin
        rdPtr   = rptr_q[c];
        rdLevel = level_q[c];
      end
      if (wch_i == CH_LOG2'(c)) begin
        wrPtr = wptr_q[c];
      end
    end
  end

  assign raddr = {rch_i, rdPtr - offset_i};
  assign waddr = {wch_i, wrPtr};

`ifdef RINGBUF_MC_UNDERRUN_MUTE_EN
  assign muteRead = (rdLevel == '0);
`else
  assign muteRead = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c]  <= '0;
        rptr_q[c]  <= '0;
        level_q[c] <= '0;
      end
      overrun_q  <= '0;
      underrun_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ch_q       <= '0;
      rdLevel_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c]  <= wptr_d[c];
        rptr_q[c]  <= rptr_d[c];
        level_q[c] <= level_d[c];
      end
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      valid_q    <= rd_i;
      // A same-address write this cycle lands after this read, so old contents are returned.
      if (rd_i) begin
        data_q    <= muteRead ? '0 : mem[raddr];
        ch_q      <= rch_i;
        rdLevel_q <= rdLevel;
      end
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign ch_o       = ch_q;
  assign level_o    = rdLevel_q;
  assign overrun_o  = overrun_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_ringbuf_mc.sv
// Self-checking bench for ringbuf_mc: queue-count reference model compared every cycle plus directed literal checks.
module tb_ringbuf_mc;

  localparam int WIDTH      = 24;
  localparam int DEPTH      = 16;
  localparam int DEPTH_LOG2 = 4;
  localparam int NUM_CH     = 2;
  localparam int CH_LOG2    = 1;
`ifdef RINGBUF_MC_UNDERRUN_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [WIDTH-1:0]      wdata_i;
  logic                  we_i;
  logic [CH_LOG2-1:0]    wch_i;
  logic                  rd_i;
  logic [CH_LOG2-1:0]    rch_i;
  logic [DEPTH_LOG2-1:0] offset_i;
  logic                  pop_i;
  logic                  clr_flags_i;
  logic [WIDTH-1:0]      data_o;
  logic                  valid_o;
  logic [CH_LOG2-1:0]    ch_o;
  logic [DEPTH_LOG2:0]   level_o;
  logic [NUM_CH-1:0]     overrun_o;
  logic [NUM_CH-1:0]     underrun_o;

  int checks = 0;
  int errors = 0;

  ringbuf_mc #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_LOG2(DEPTH_LOG2), .NUM_CH(NUM_CH), .CH_LOG2(CH_LOG2)
  ) dut (
    .clk(clk), .rst(rst), .wdata_i(wdata_i), .we_i(we_i), .wch_i(wch_i), .rd_i(rd_i),
    .rch_i(rch_i), .offset_i(offset_i), .pop_i(pop_i), .clr_flags_i(clr_flags_i),
    .data_o(data_o), .valid_o(valid_o), .ch_o(ch_o), .level_o(level_o),
    .overrun_o(overrun_o), .underrun_o(underrun_o)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs right after a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input bit we, input int wch, input int wd, input bit rd,
                               input int rch, input int off, input bit pop, input bit clr);
    we_i        = we;
    wch_i       = CH_LOG2'(wch);
    wdata_i     = WIDTH'(wd);
    rd_i        = rd;
    rch_i       = CH_LOG2'(rch);
    offset_i    = DEPTH_LOG2'(off);
    pop_i       = pop;
    clr_flags_i = clr;
    @(negedge clk);
  endtask

  task automatic doWrite(input int ch, input int d);
    applyStimulus(1'b1, ch, d, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic doRead(input int ch, input int off);
    applyStimulus(1'b0, 0, 0, 1'b1, ch, off, 1'b0, 1'b0);
  endtask

  task automatic doPop(input int ch);
    applyStimulus(1'b0, 0, 0, 1'b0, ch, 0, 1'b1, 1'b0);
  endtask

  task automatic doIdle();
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // Reference model: each channel is a count of samples ever written and ever consumed.
  int               wcnt [NUM_CH];
  int               rcnt [NUM_CH];
  logic [WIDTH-1:0] mmem [NUM_CH][DEPTH];
  bit               mknown [NUM_CH][DEPTH];
  logic [WIDTH-1:0] expData;
  bit               expValid;
  bit               expKnown;
  int               expCh;
  int               expLevel;
  logic [NUM_CH-1:0] expOv;
  logic [NUM_CH-1:0] expUn;

  initial begin
    int lv [NUM_CH];
    int idx;
    int rc;
    int wc;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int c = 0; c < NUM_CH; c++) begin
          wcnt[c] = 0;
          rcnt[c] = 0;
        end
        expOv    = '0;
        expUn    = '0;
        expData  = '0;
        expValid = 1'b0;
        expKnown = 1'b1;
        expCh    = 0;
        expLevel = 0;
      end else begin
        rc = int'(rch_i);
        wc = int'(wch_i);
        for (int c = 0; c < NUM_CH; c++) lv[c] = wcnt[c] - rcnt[c];
        expValid = rd_i;
        if (rd_i) begin
          expCh    = rc;
          expLevel = lv[rc];
          idx = ((rcnt[rc] - int'(offset_i)) % DEPTH + DEPTH) % DEPTH;
          if (MUTE && lv[rc] == 0) begin
            expData  = '0;
            expKnown = 1'b1;
          end else begin
            expData  = mmem[rc][idx];
            expKnown = mknown[rc][idx];
          end
        end
        if (clr_flags_i) begin
          expOv = '0;
          expUn = '0;
        end
        if (we_i) begin
          if (lv[wc] == DEPTH && !(pop_i && rc == wc)) begin
            rcnt[wc]++;
            expOv[wc] = 1'b1;
          end
          mmem[wc][wcnt[wc] % DEPTH]   = wdata_i;
          mknown[wc][wcnt[wc] % DEPTH] = 1'b1;
          wcnt[wc]++;
        end
        if (pop_i) begin
          if (lv[rc] > 0) rcnt[rc]++;
          else expUn[rc] = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    checkOutput("cmp_valid", 32'(valid_o), 32'(expValid));
    checkOutput("cmp_ch", 32'(ch_o), 32'(expCh));
    checkOutput("cmp_level", 32'(level_o), 32'(expLevel));
    if (expKnown) checkOutput("cmp_data", 32'(data_o), 32'(expData));
    checkOutput("cmp_overrun", 32'(overrun_o), 32'(expOv));
    checkOutput("cmp_underrun", 32'(underrun_o), 32'(expUn));
  end

  initial begin
    we_i = 1'b0; wch_i = '0; wdata_i = '0; rd_i = 1'b0; rch_i = '0;
    offset_i = '0; pop_i = 1'b0; clr_flags_i = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_data", 32'(data_o), 32'h0);
    checkOutput("rst_valid", 32'(valid_o), 32'h0);
    checkOutput("rst_level", 32'(level_o), 32'h0);
    checkOutput("rst_flags", 32'({overrun_o, underrun_o}), 32'h0);
    rst = 1'b1;
    doIdle();

    for (int i = 1; i <= 4; i++) doWrite(0, i);
    doRead(0, 0);
    checkOutput("t1_data", 32'(data_o), 32'h1);
    checkOutput("t1_level", 32'(level_o), 32'd4);
    checkOutput("t1_valid", 32'(valid_o), 32'h1);
    doIdle();
    checkOutput("t1_valid_pulse", 32'(valid_o), 32'h0);

    for (int i = 'h10; i <= 'h20; i++) doWrite(1, i);
    doRead(1, 0);
    checkOutput("t2_data", 32'(data_o), 32'h11);
    checkOutput("t2_level", 32'(level_o), 32'd16);
    checkOutput("t2_overrun", 32'(overrun_o), 32'h2);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    checkOutput("t2_clr", 32'(overrun_o), 32'h0);

    repeat (4) doPop(0);
    doPop(0);
    checkOutput("t3_underrun", 32'(underrun_o), 32'h1);
    doRead(0, 1);
    checkOutput("t3_data", 32'(data_o), MUTE ? 32'h0 : 32'h4);
    checkOutput("t3_level", 32'(level_o), 32'h0);

    doWrite(0, 'hA);
    doWrite(0, 'hB);
    doWrite(0, 'hC);
    doPop(0);
    doPop(0);
    doRead(0, 2);
    checkOutput("t4_hist", 32'(data_o), 32'hA);
    applyStimulus(1'b0, 0, 0, 1'b1, 0, 0, 1'b1, 1'b0);
    checkOutput("t4_rdpop_data", 32'(data_o), 32'hC);
    checkOutput("t4_rdpop_level", 32'(level_o), 32'd1);
    doRead(0, 1);
    checkOutput("t4_level0", 32'(level_o), 32'd0);

    applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) doWrite(0, 'h100 + i);
    applyStimulus(1'b1, 0, 'h200, 1'b0, 0, 0, 1'b1, 1'b0);
    doRead(0, 0);
    checkOutput("t5_data", 32'(data_o), 32'h101);
    checkOutput("t5_level", 32'(level_o), 32'd16);
    checkOutput("t5_no_overrun", 32'(overrun_o), 32'h0);
    applyStimulus(1'b1, 0, 'h300, 1'b0, 1, 0, 1'b1, 1'b0);
    doWrite(0, 'h301);
    doRead(1, 0);
    checkOutput("t5_ch1_level", 32'(level_o), 32'd15);
    checkOutput("t5_ch1_data", 32'(data_o), 32'h12);
    checkOutput("t5_overrun", 32'(overrun_o), 32'h1);
    doRead(0, 0);
    checkOutput("t5_ch0_level", 32'(level_o), 32'd16);
    checkOutput("t5_ch0_data", 32'(data_o), 32'h103);

    we_i = 1'b1; wch_i = '0; wdata_i = 24'h400; rd_i = 1'b1; rch_i = 1'b1;
    offset_i = '0; pop_i = 1'b0; clr_flags_i = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("t6_data", 32'(data_o), 32'h0);
    checkOutput("t6_valid", 32'(valid_o), 32'h0);
    checkOutput("t6_level", 32'(level_o), 32'h0);
    checkOutput("t6_flags", 32'({overrun_o, underrun_o, ch_o}), 32'h0);
    we_i = 1'b0; rd_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    doWrite(1, 'h55);
    doRead(1, 0);
    checkOutput("t6_restart_data", 32'(data_o), 32'h55);
    checkOutput("t6_restart_level", 32'(level_o), 32'd1);
    doRead(0, 0);
    checkOutput("t6_ch0_level", 32'(level_o), 32'd0);
    checkOutput("t6_ch0_valid", 32'(valid_o), 32'h1);
    doIdle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
